// File: rtl/sync_up_counter_ctrl.sv
// ============================================================================
//  Module      : sync_up_counter_ctrl
//  Description : Loadable up counter with a programmable terminal value and an
//                IDLE/RUN/DONE run-control FSM. It counts from d toward limit,
//                pulses tc for one clock on the terminal count, then either
//                stops in DONE (one-shot) or reloads d and keeps running (wrap).
//                Optional macro COUNTER_PRESCALE_EN adds a clock prescaler so
//                that a count step happens only once every PRESCALE clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_up_counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,     // asynchronous, active low
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,    // 0 = one-shot, 1 = auto-reload
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             w_step;      // this RUN edge may increment / compare

`ifdef COUNTER_PRESCALE_EN
    localparam int                 c_psc_w    = $clog2(PRESCALE);
    localparam logic [c_psc_w-1:0] c_psc_last = c_psc_w'(PRESCALE - 1);

    logic [c_psc_w-1:0] r_psc;
    logic [c_psc_w-1:0] w_psc_nxt;

    assign w_step = (r_psc == c_psc_last);

    // Prescaler advances only while running; every other case (load, stop,
    // idle, done, or a completed step) returns it to zero, which also gives
    // the clear on the IDLE->RUN edge.
    always_comb begin
        w_psc_nxt = '0;
        if (!load && (r_state == ST_RUN) && !stop && !w_step) begin
            w_psc_nxt = r_psc + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_psc <= '0;
        end else begin
            r_psc <= w_psc_nxt;
        end
    end
`else
    logic w_unused_prescale;

    // Without the prescaler every RUN edge is a count step.
    assign w_step            = 1'b1;
    assign w_unused_prescale = (PRESCALE == 0);
`endif

    // Next-state, next-count and terminal-count decode; priority is
    // load > stop > start > count.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_tc_nxt    = 1'b0;

        if (load) begin
            w_q_nxt     = d;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // stop beats start, so both high keeps us idle
                    if (start && !stop) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_step) begin
                        if (r_q == limit) begin
                            w_tc_nxt = 1'b1;
                            if (mode) begin
                                w_q_nxt = d;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            // natural modulo 2^WIDTH roll-over
                            w_q_nxt = r_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // only load or reset leaves DONE
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, count and terminal-count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_sync_up_counter_ctrl.sv
// ============================================================================
//  Module      : tb_sync_up_counter_ctrl
//  Description : Scoreboard bench for sync_up_counter_ctrl (default build, no
//                prescaler). A driver issues directed and random cycles and
//                pushes the reference model's prediction; a monitor pops and
//                compares one prediction after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_up_counter_ctrl;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d;
    logic [W-1:0] limit;
    logic         load;
    logic         start;
    logic         stop;
    logic         mode;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;

    sync_up_counter_ctrl #(.WIDTH(W), .PRESCALE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .limit (limit),
        .load  (load),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .q     (q),
        .tc    (tc),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int sb[$];            // predicted {q,tc,busy,done}, one per clock edge

    // Reference model: count value plus "running"/"finished" flags
    int m_q     = 0;
    bit m_run   = 1'b0;
    bit m_fin   = 1'b0;

    // Values currently offered on d / limit / mode
    int dv = 0;
    int lv = 0;
    bit md = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h ({q,tc,busy,done})", name, act, exp);
        end
    endtask

    function automatic int pack(input int qq, input bit t, input bit b, input bit dn);
        return (qq << 3) | (int'(t) << 2) | (int'(b) << 1) | int'(dn);
    endfunction

    // Drive one clock worth of inputs and queue what the next edge must show.
    task automatic cycle(input bit ld, input bit st, input bit sp);
        bit t;
        @(negedge clk);
        load  = ld;
        start = st;
        stop  = sp;
        d     = dv[W-1:0];
        limit = lv[W-1:0];
        mode  = md;
        t = 1'b0;
        if (ld) begin
            m_q   = dv;
            m_run = 1'b0;
            m_fin = 1'b0;
        end else if (m_run) begin
            if (sp) begin
                m_run = 1'b0;
            end else if (m_q == lv) begin
                t = 1'b1;
                if (md) begin
                    m_q = dv;
                end else begin
                    m_run = 1'b0;
                    m_fin = 1'b1;
                end
            end else begin
                m_q = (m_q + 1) % MOD;
            end
        end else if (!m_fin) begin
            if (st && !sp) m_run = 1'b1;
        end
        sb.push_back(pack(m_q, t, m_run, m_fin));
    endtask

    function automatic int dut_word();
        int v;
        v = 0;
        v[W+2:0] = {q, tc, busy, done};
        return v;
    endfunction

    // Monitor: every edge with a pending prediction is checked
    initial begin
        int e;
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("edge%0d", k), dut_word(), e);
                k++;
            end
        end
    end

    // Async reset asserted between edges must clear outputs at once.
    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk(name, dut_word(), pack(0, 1'b0, 1'b0, 1'b0));
        m_q = 0; m_run = 1'b0; m_fin = 1'b0;
        @(negedge clk);
        load = 1'b0; start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk({name, "_held"}, dut_word(), pack(0, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b0; d = '0; limit = '0; load = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        #1;
        chk("reset_init", dut_word(), pack(0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // One-shot 3..6, later start ignored in DONE
        dv = 3; lv = 6; md = 1'b0;
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        repeat (6) cycle(0, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // Auto-reload 2,3,4,2,...
        dv = 2; lv = 4; md = 1'b1;
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        repeat (10) cycle(0, 0, 0);

        // Wrap-around 14,15,0,1 then terminal
        dv = 14; lv = 1; md = 1'b0;
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        repeat (6) cycle(0, 0, 0);

        // Reset mid-RUN at q=5
        dv = 0; lv = 15; md = 1'b0;
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < 20 && m_q != 5; i++) cycle(0, 0, 0);
        async_reset("reset_midrun");

        // Stop at q=9 holds the count
        dv = 5; lv = 12; md = 1'b0;
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < 20 && m_q != 9; i++) cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // load and stop together: load wins
        dv = 11;
        cycle(1, 0, 1);
        // start and stop together in IDLE: stays idle
        cycle(0, 1, 1);
        cycle(0, 0, 0);

        // d == limit: terminal on first RUN edge without increment
        dv = 7; lv = 7; md = 1'b0;
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) dv = int'($urandom_range(MOD - 1));
            if ($urandom_range(7) == 0) lv = int'($urandom_range(MOD - 1));
            if ($urandom_range(15) == 0) md = 1'($urandom_range(1));
            cycle($urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0);
        end

        cycle(0, 0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_up_counter_ctrl.md
Name: sync_up_counter_ctrl

Overview:
- Loadable, programmable-limit up counter with a small run-control FSM.
- Counterpart to the team's down counter: counts up from a loaded start value `d` toward `limit`.
- Flags the terminal count, then either stops (one-shot) or reloads and continues (wrap).
- Used as the event and timeout counter alongside the down-counter blocks in the same clock domain.

Parameters:
- WIDTH, 4, bit width of d, limit and q.
- PRESCALE, 4, clocks per count step; used only when COUNTER_PRESCALE_EN is defined; legal values 2 to 256.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; rst=0 resets immediately.
- d  input  WIDTH  start/reload value.
- limit  input  WIDTH  terminal value.
- load  input  1  synchronous load of d into q.
- start  input  1  begin counting.
- stop  input  1  halt counting.
- mode  input  1  0 = one-shot, 1 = auto-reload (wrap).
- q  output  WIDTH  current count.
- tc  output  1  terminal-count pulse.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - q=0, tc=0, busy=0, done=0, state=IDLE.
  - Held while rst=0; the first active edge is the first rising clk after rst returns to 1.
  - Reset mid-RUN aborts immediately; no tc is produced.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1.
  - busy and done are decoded from registered state.
- Priority per edge: load > stop > start > count.
- load (any state): q<=d, state<=IDLE, tc<=0.
- IDLE: start=1 -> RUN. q is unchanged on the transition edge; the first increment occurs on the following edge.
- RUN, stop=1: -> IDLE, q holds, tc<=0.
- RUN, q!=limit: q<=q+1 modulo 2^WIDTH, so 2^WIDTH-1 wraps to 0 and counting continues.
- RUN, q==limit, mode=0: q holds, state<=DONE, tc<=1.
- RUN, q==limit, mode=1: q<=d, stays RUN, tc<=1.
- tc is registered. It is high for exactly one clk period after the edge at which RUN observed q==limit, and is 0 on every other edge.
- d==limit at start: the first RUN edge detects the terminal count; tc fires with no increment.
- d>limit: the count passes through wrap-around (2^WIDTH-1 -> 0) before reaching limit.
- DONE:
  - start and stop are ignored; q holds.
  - Exits only via load (-> IDLE) or reset.
- IDLE: stop ignored; start and stop both high in IDLE -> stop wins, so the state stays IDLE.
- d, limit and mode are sampled every edge; changing limit mid-RUN takes effect on the next compare.
- Latency: start edge to first increment = 2 edges; terminal edge to tc visible = 0 cycles after that edge (registered output).

Optional Feature:
- Macro COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescale counter runs 0..PRESCALE-1 while in RUN.
  - The prescale counter clears to 0 on reset, on load, and on the IDLE->RUN edge.
  - Increment and terminal compare happen only on edges where the prescaler equals PRESCALE-1, so tc still lasts exactly one clk.
  - stop and load act immediately, independent of the prescaler.
- Undefined:
  - No prescaler logic is present.
  - Increment and compare happen on every RUN edge.
  - PRESCALE is unused.

Test Plan:
- Reset check: rst=0 asserted mid-RUN (q=5) -> q=0, busy=0, done=0, tc=0 immediately, without waiting for clk.
- One-shot count: WIDTH=4, load d=3, limit=6, mode=0, pulse start -> q steps 3,4,5,6 on successive edges; the next edge gives tc=1 for one cycle, done=1, q stays 6; a later start is ignored.
- Auto-reload: d=2, limit=4, mode=1 -> q sequence 2,3,4,2,3,4…; tc pulses once per period (every 3 edges); busy stays 1.
- Wrap-around: d=14, limit=1, mode=0 -> q 14,15,0,1, then tc=1 and done=1.
- Priority and stop:
  - stop at q=9 -> IDLE, q holds 9.
  - load and stop asserted on the same edge -> q=d, IDLE.
  - d==limit=7, then start -> tc on the first RUN edge with q=7.
- Prescale, with COUNTER_PRESCALE_EN and PRESCALE=4: d=0, limit=2 -> q increments every 4 clk; tc lasts 1 clk, 12 edges after the start edge.
